biriscv_inst_queue: RTL and testbench

- Fetch-side instruction queue. It buffers 64-bit fetch packets (two 32-bit instruction slots) from the fetch unit.
- It presents them one instruction per cycle, with PC and fault flag, to the decode stage (opcode/valid/fault inputs of the decoder).
- It is the producer end of the decoder's instruction interface.
- It absorbs fetch/decode rate mismatch and discards everything on a pipeline flush.

---
 rtl/biriscv_inst_queue.sv | 144 ++++++++++++++
 tb/tb_biriscv_inst_queue.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : biriscv_inst_queue
// Description : Fetch-side instruction queue. Buffers 64-bit fetch packets
//               (two 32-bit slots) and presents one instruction per cycle,
//               with PC and fault flag, to the decode stage. Flush discards
//               all buffered packets.
// Revision    : 1.0 - initial release
// ============================================================================
module biriscv_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              fetch_valid_i,
  input  logic [63:0]       fetch_instr_i,
  input  logic [31:0]       fetch_pc_i,
  input  logic              fetch_fault_i,
  output logic              fetch_accept_o,
  output logic              valid_o,
  output logic [31:0]       opcode_o,
  output logic [31:0]       pc_o,
  output logic              fault_o,
  input  logic              accept_i,
  output logic [ADDR_W:0]   level_o
);

  localparam logic [ADDR_W:0]   c_full_count = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);

  // One queue entry: the whole packet, the 8-byte aligned packet PC, the slot
  // the first valid instruction lives in, and the fetch fault flag.
  typedef struct packed {
    logic [63:0] instr;
    logic [28:0] pc;
    logic        start_slot;
    logic        fault;
  } entry_t;

  entry_t            mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              slot_q,   slot_d;

  entry_t            head;
  entry_t            wr_entry;
  logic              cur_slot;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic              retire;

  // The low two PC bits carry no information for 32-bit aligned instructions.
  logic              unused_pc_bits;
  assign unused_pc_bits = ^fetch_pc_i[1:0];

  // Head decode, handshakes and gated decode-side outputs.
  always_comb begin
    head           = mem_q[rd_ptr_q];
    not_empty      = (count_q != '0);
    cur_slot       = slot_q | head.start_slot;

    // Accept depends on occupancy only, never on a same-cycle pop, so the
    // fetch unit sees a registered-quality ready.
    fetch_accept_o = (count_q != c_full_count);
    push           = fetch_valid_i & fetch_accept_o & ~flush_i;

    valid_o        = not_empty & ~flush_i;
    pop            = valid_o & accept_i;
    // A faulting packet carries no usable second instruction, so it retires
    // after its single beat regardless of which slot that beat came from.
    retire         = pop & (cur_slot | head.fault);

    opcode_o       = '0;
    pc_o           = '0;
    fault_o        = 1'b0;
    if (valid_o) begin
      opcode_o = cur_slot ? head.instr[63:32] : head.instr[31:0];
      pc_o     = {head.pc, cur_slot, 2'b00};
      fault_o  = head.fault;
    end

    level_o        = count_q;

    wr_entry.instr      = fetch_instr_i;
    wr_entry.pc         = fetch_pc_i[31:3];
    wr_entry.start_slot = fetch_pc_i[2];
    wr_entry.fault      = fetch_fault_i;
  end

  // Next-state for pointers, occupancy and the head slot cursor; flush wins.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    slot_d   = slot_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      slot_d   = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + c_ptr_one;
      end
      if (retire) begin
        rd_ptr_d = rd_ptr_q + c_ptr_one;
        slot_d   = 1'b0;
      end else if (pop) begin
        slot_d   = 1'b1;
      end
      count_d = count_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, retire};
    end
  end

  // Control state register; reset drops everything immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      slot_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      slot_q   <= slot_d;
    end
  end

  // Packet storage; contents are don't-care until counted as occupied.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_biriscv_inst_queue.sv
`timescale 1ns/1ps
`default_nettype none
module tb_biriscv_inst_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic              fetch_valid_i = 1'b0;
  logic [63:0]       fetch_instr_i = '0;
  logic [31:0]       fetch_pc_i = '0;
  logic              fetch_fault_i = 1'b0;
  logic              fetch_accept_o;
  logic              valid_o;
  logic [31:0]       opcode_o;
  logic [31:0]       pc_o;
  logic              fault_o;
  logic              accept_i = 1'b0;
  logic [ADDR_W:0]   level_o;

  int                vectors = 0;
  int                miscompares = 0;
  logic [64:0]       sb[$];          // {fault, pc, opcode} per expected beat
  logic [64:0]       sb_exp;

  biriscv_inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_instr_i  (fetch_instr_i),
    .fetch_pc_i     (fetch_pc_i),
    .fetch_fault_i  (fetch_fault_i),
    .fetch_accept_o (fetch_accept_o),
    .valid_o        (valid_o),
    .opcode_o       (opcode_o),
    .pc_o           (pc_o),
    .fault_o        (fault_o),
    .accept_i       (accept_i),
    .level_o        (level_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard consumer: every consumed beat must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && accept_i) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL beat: got fault=%b pc=%h op=%h, required no beat", fault_o, pc_o, opcode_o);
      end else begin
        sb_exp = sb.pop_front();
        if ({fault_o, pc_o, opcode_o} !== sb_exp) begin
          miscompares++;
          $display("FAIL beat: got fault=%b pc=%h op=%h, required fault=%b pc=%h op=%h",
                   fault_o, pc_o, opcode_o, sb_exp[64], sb_exp[63:32], sb_exp[31:0]);
        end
      end
    end else if (rst_ni && !valid_o) begin
      vectors++;
      if ({fault_o, pc_o, opcode_o} !== 65'd0) begin
        miscompares++;
        $display("FAIL idle_zero: got fault=%b pc=%h op=%h, required all zero", fault_o, pc_o, opcode_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a packet and, if it will be accepted, queue the beats it must yield.
  task automatic drive_packet(input logic [31:0] pc, input logic [63:0] instr,
                              input logic fault, input bit expect_it);
    fetch_valid_i = 1'b1;
    fetch_pc_i    = pc;
    fetch_instr_i = instr;
    fetch_fault_i = fault;
    if (expect_it) begin
      if (fault || pc[2]) begin
        sb.push_back({fault, pc[31:3], pc[2], 2'b00, (pc[2] ? instr[63:32] : instr[31:0])});
      end else begin
        sb.push_back({1'b0, pc[31:3], 3'b000, instr[31:0]});
        sb.push_back({1'b0, pc[31:3], 3'b100, instr[63:32]});
      end
    end
  endtask

  task automatic idle_fetch();
    fetch_valid_i = 1'b0;
    fetch_fault_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    @(negedge clk_i);
    vectors++;
    if ({valid_o, opcode_o, pc_o, fault_o, level_o, fetch_accept_o} !== {1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b op=%h pc=%h fault=%b level=%0d acc=%b, required 0/0/0/0/0/1",
               valid_o, opcode_o, pc_o, fault_o, level_o, fetch_accept_o);
    end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    accept_i = 1'b1;
    drive_packet(32'h8000_0000, 64'h00208133_00100093, 1'b0, 1'b1);
    tick();
    idle_fetch();
    tick();
    tick();
    @(negedge clk_i);
    vectors++;
    if ({valid_o, level_o, sb.size() == 0} !== {1'b0, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL basic_done: got valid=%b level=%0d pending=%0d, required 0/0/0", valid_o, level_o, sb.size());
    end
  endtask

  task automatic test_odd_start();
    accept_i = 1'b0;
    drive_packet(32'h8000_0104, 64'h00000013_DEADBEEF, 1'b0, 1'b1);
    tick();
    idle_fetch();
    @(negedge clk_i);
    vectors++;
    if ({valid_o, level_o} !== {1'b1, 3'd1}) begin
      miscompares++;
      $display("FAIL odd_level1: got valid=%b level=%0d, required 1/1", valid_o, level_o);
    end
    tick();
    accept_i = 1'b1;
    tick();
    @(negedge clk_i);
    vectors++;
    if ({valid_o, level_o, sb.size() == 0} !== {1'b0, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL odd_retire: got valid=%b level=%0d pending=%0d, required 0/0/0", valid_o, level_o, sb.size());
    end
  endtask

  task automatic test_fault();
    accept_i = 1'b1;
    drive_packet(32'h8000_0008, 64'h11111111_22222222, 1'b1, 1'b1);
    tick();
    drive_packet(32'h8000_0010, 64'h00418233_00310193, 1'b0, 1'b1);
    tick();
    idle_fetch();
    tick();
    tick();
    @(negedge clk_i);
    vectors++;
    if ({valid_o, level_o, sb.size() == 0} !== {1'b0, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL fault_seq: got valid=%b level=%0d pending=%0d, required 0/0/0", valid_o, level_o, sb.size());
    end
  endtask

  task automatic test_full_backpressure();
    accept_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drive_packet(32'h8000_0200 + 32'(k * 8), {32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k)}, 1'b0, 1'b1);
      tick();
    end
    drive_packet(32'h8000_0300, 64'hC0C0C0C0_D0D0D0D0, 1'b0, 1'b0);
    @(negedge clk_i);
    vectors++;
    if ({level_o, fetch_accept_o} !== {3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL full_level: got level=%0d acc=%b, required 4/0", level_o, fetch_accept_o);
    end
    tick();
    accept_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if ({level_o, fetch_accept_o} !== {3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL full_held: got level=%0d acc=%b, required 4/0", level_o, fetch_accept_o);
    end
    tick();
    @(negedge clk_i);
    vectors++;
    if (fetch_accept_o !== 1'b0) begin
      miscompares++;
      $display("FAIL full_no_sameCycle: got acc=%b, required 0", fetch_accept_o);
    end
    tick();
    accept_i = 1'b0;
    drive_packet(32'h8000_0300, 64'hC0C0C0C0_D0D0D0D0, 1'b0, 1'b1);
    @(negedge clk_i);
    vectors++;
    if ({level_o, fetch_accept_o} !== {3'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL full_after_retire: got level=%0d acc=%b, required 3/1", level_o, fetch_accept_o);
    end
    tick();
    idle_fetch();
    @(negedge clk_i);
    vectors++;
    if ({level_o, fetch_accept_o} !== {3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL full_refill: got level=%0d acc=%b, required 4/0", level_o, fetch_accept_o);
    end
    tick();
    accept_i = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    @(negedge clk_i);
    vectors++;
    if ({valid_o, level_o, sb.size() == 0} !== {1'b0, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL full_drain: got valid=%b level=%0d pending=%0d, required 0/0/0", valid_o, level_o, sb.size());
    end
  endtask

  task automatic test_flush();
    accept_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_packet(32'h8000_0400 + 32'(k * 8), {32'hE000_0000 + 32'(k), 32'hF000_0000 + 32'(k)}, 1'b0, 1'b1);
      tick();
    end
    idle_fetch();
    @(negedge clk_i);
    vectors++;
    if (level_o !== 3'd3) begin
      miscompares++;
      $display("FAIL flush_prefill: got level=%0d, required 3", level_o);
    end
    tick();
    flush_i  = 1'b1;
    accept_i = 1'b1;
    drive_packet(32'h8000_0500, 64'h99999999_88888888, 1'b0, 1'b0);
    @(negedge clk_i);
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_valid: got valid=%b, required 0", valid_o);
    end
    tick();
    flush_i = 1'b0;
    idle_fetch();
    sb.delete();
    @(negedge clk_i);
    vectors++;
    if ({level_o, valid_o, fetch_accept_o} !== {3'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL flush_after: got level=%0d valid=%b acc=%b, required 0/0/1", level_o, valid_o, fetch_accept_o);
    end
    tick();
    tick();
    @(negedge clk_i);
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_discard: got valid=%b, required 0", valid_o);
    end
  endtask

  task automatic test_async_reset();
    accept_i = 1'b0;
    drive_packet(32'h8000_0600, 64'h12345678_9ABCDEF0, 1'b0, 1'b1);
    tick();
    drive_packet(32'h8000_0608, 64'h0FEDCBA9_87654321, 1'b0, 1'b1);
    tick();
    idle_fetch();
    @(negedge clk_i);
    vectors++;
    if ({valid_o, level_o} !== {1'b1, 3'd2}) begin
      miscompares++;
      $display("FAIL areset_pre: got valid=%b level=%0d, required 1/2", valid_o, level_o);
    end
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    vectors++;
    if ({valid_o, level_o} !== {1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL areset_async: got valid=%b level=%0d, required 0/0", valid_o, level_o);
    end
    sb.delete();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_start();
    test_fault();
    test_full_backpressure();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
